// File: rtl/pencoder_inverse_acc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pencoder_inverse_acc : rebuilds a 32-bit mask from MSB-first index tokens
// Revision 1.0
// ---------------------------------------------------------------------------
module pencoder_inverse_acc #(
  parameter int MASK_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_val,
  output logic              in_rdy,
  input  logic [4:0]        in_idx,
  input  logic              in_empty,
  input  logic              in_last,
  output logic              out_val,
  input  logic              out_rdy,
  output logic [MASK_W-1:0] out_mask,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              out_dup
);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [MASK_W-1:0] TOP_BIT = {1'b1, {(MASK_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [MASK_W-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dup_q, dup_d;
  logic              in_rdy_q, in_rdy_d;
  logic              out_val_q, out_val_d;

  logic              accept;
  logic [MASK_W-1:0] tok_bit;

  assign accept  = in_val & in_rdy_q;
  // Index 0 names the MSB, so the token bit walks down from the top.
  assign tok_bit = TOP_BIT >> in_idx;

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    cnt_d     = cnt_q;
    dup_d     = dup_q;
    in_rdy_d  = in_rdy_q;
    out_val_d = out_val_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (!in_empty) begin
            mask_d = mask_q | tok_bit;
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
            if ((mask_q & tok_bit) != '0) dup_d = 1'b1;
          end
          if (in_last) begin
            state_d   = HOLD;
            in_rdy_d  = 1'b0;
            out_val_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_rdy) begin
          state_d   = ACCUM;
          mask_d    = '0;
          cnt_d     = '0;
          dup_d     = 1'b0;
          in_rdy_d  = 1'b1;
          out_val_d = 1'b0;
        end
      end
      default: begin
        state_d   = ACCUM;
        in_rdy_d  = 1'b1;
        out_val_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACCUM;
      mask_q    <= '0;
      cnt_q     <= '0;
      dup_q     <= 1'b0;
      in_rdy_q  <= 1'b1;
      out_val_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      cnt_q     <= cnt_d;
      dup_q     <= dup_d;
      in_rdy_q  <= in_rdy_d;
      out_val_q <= out_val_d;
    end
  end

  assign in_rdy   = in_rdy_q;
  assign out_val  = out_val_q;
  assign out_mask = mask_q;
  assign out_cnt  = cnt_q;
  assign out_dup  = dup_q;

endmodule
`default_nettype wire

// File: tb/tb_pencoder_inverse_acc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pencoder_inverse_acc : directed and randomized checks of mask rebuilding
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_pencoder_inverse_acc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_val = 1'b0;
  logic        in_rdy;
  logic [4:0]  in_idx = '0;
  logic        in_empty = 1'b0;
  logic        in_last = 1'b0;
  logic        out_val;
  logic        out_rdy = 1'b0;
  logic [31:0] out_mask;
  logic [5:0]  out_cnt;
  logic        out_dup;

  int tests = 0;
  int fails = 0;

  pencoder_inverse_acc #(.MASK_W(32), .CNT_W(6)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .in_idx   (in_idx),
    .in_empty (in_empty),
    .in_last  (in_last),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .out_mask (out_mask),
    .out_cnt  (out_cnt),
    .out_dup  (out_dup)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One token per call; checks acceptance readiness and, on a last token, the 1-cycle latency.
  task automatic send(input int idx, input bit empty, input bit last);
    @(negedge clk);
    chk("in_rdy_before_token", {31'b0, in_rdy}, 32'd1);
    in_val   = 1'b1;
    in_idx   = 5'(idx);
    in_empty = empty;
    in_last  = last;
    @(posedge clk);
    #1;
    in_val  = 1'b0;
    in_last = 1'b0;
    in_empty = 1'b0;
    if (last) chk("out_val_latency", {31'b0, out_val}, 32'd1);
  endtask

  // Holds the expected result stable across random stalls, then confirms the clear.
  task automatic drain(input logic [31:0] em, input int ec, input bit ed, input bit stall);
    bit done = 1'b0;
    for (int n = 0; n < 64 && !done; n++) begin
      @(negedge clk);
      out_rdy = stall ? ($urandom_range(0, 3) == 0) : 1'b1;
      chk("hold_out_val", {31'b0, out_val}, 32'd1);
      chk("hold_in_rdy", {31'b0, in_rdy}, 32'd0);
      chk("out_mask", out_mask, em);
      chk("out_cnt", {26'b0, out_cnt}, 32'(ec));
      chk("out_dup", {31'b0, out_dup}, {31'b0, ed});
      @(posedge clk);
      if (out_rdy) done = 1'b1;
    end
    chk("drain_timeout", {31'b0, done}, 32'd1);
    #1;
    out_rdy = 1'b0;
    chk("post_in_rdy", {31'b0, in_rdy}, 32'd1);
    chk("post_out_val", {31'b0, out_val}, 32'd0);
    chk("post_mask_clear", out_mask, 32'd0);
    chk("post_cnt_clear", {26'b0, out_cnt}, 32'd0);
  endtask

  // Reference: repeatedly take the highest set bit (priority encode), emit its index, clear it.
  task automatic run_mask(input logic [31:0] m, input bit stall);
    logic [31:0] rem = m;
    int pop = 0;
    if (m == 32'd0) send(0, 1'b1, 1'b1);
    while (rem != 32'd0) begin
      int pos = 31;
      while (!rem[pos]) pos--;
      rem[pos] = 1'b0;
      pop++;
      send(31 - pos, 1'b0, rem == 32'd0);
    end
    drain(m, pop, 1'b0, stall);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_out_val", {31'b0, out_val}, 32'd0);
    chk("rst_mask", out_mask, 32'd0);
    chk("rst_cnt", {26'b0, out_cnt}, 32'd0);
    chk("rst_dup", {31'b0, out_dup}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_release_in_rdy", {31'b0, in_rdy}, 32'd1);

    // idx 0 and 31 -> both mask ends
    send(0, 1'b0, 1'b0);
    send(31, 1'b0, 1'b1);
    drain(32'h8000_0001, 2, 1'b0, 1'b0);

    // duplicate index sets sticky dup
    send(5, 1'b0, 1'b0);
    send(5, 1'b0, 1'b1);
    drain(32'h0400_0000, 2, 1'b1, 1'b0);

    // empty-and-last token means an all-zero mask
    send(0, 1'b1, 1'b1);
    drain(32'd0, 0, 1'b0, 1'b0);

    // empty tokens mixed in leave mask and count alone
    send(9, 1'b1, 1'b0);
    send(1, 1'b0, 1'b0);
    send(2, 1'b1, 1'b1);
    drain(32'h4000_0000, 1, 1'b0, 1'b0);

    // Backpressure: 4 stalled cycles with tokens offered must be ignored
    send(3, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      out_rdy = 1'b0;
      in_val  = 1'b1;
      in_idx  = 5'd7;
      in_last = 1'b1;
      chk("stall_in_rdy", {31'b0, in_rdy}, 32'd0);
      chk("stall_mask", out_mask, 32'h1000_0000);
      chk("stall_cnt", {26'b0, out_cnt}, 32'd1);
      chk("stall_out_val", {31'b0, out_val}, 32'd1);
    end
    @(negedge clk);
    in_val = 1'b0;
    in_last = 1'b0;
    drain(32'h1000_0000, 1, 1'b0, 1'b0);

    // Count saturates at 63
    for (int i = 0; i < 64; i++) send(0, 1'b0, 1'b0);
    send(0, 1'b0, 1'b1);
    drain(32'h8000_0000, 63, 1'b1, 1'b0);

    // Reset mid-mask discards partial accumulation
    send(1, 1'b0, 1'b0);
    send(4, 1'b0, 1'b0);
    send(8, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_val", {31'b0, out_val}, 32'd0);
    chk("midrst_mask", out_mask, 32'd0);
    chk("midrst_cnt", {26'b0, out_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(20, 1'b0, 1'b1);
    drain(32'h0000_0800, 1, 1'b0, 1'b0);

    // Randomized masks with random output stalls
    for (int t = 0; t < 20; t++) begin
      logic [31:0] m;
      m = $urandom();
      if (t == 0) m = 32'hFFFF_FFFF;
      if (t == 1) m = 32'd0;
      if (t % 5 == 4) m = m & $urandom();
      run_mask(m, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pencoder_inverse_acc.md
PENCODER_INVERSE_ACC -- requirements
Module: pencoder_inverse_acc

Interface
REQ-001 Parameter MASK_W, default 32: width of the rebuilt bitmask; fixed at 32 for this block, and other values are unsupported.
REQ-002 Parameter CNT_W, default 6: width of the index counter.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous assert and active-low.
REQ-005 Port in_val, input, 1: index token valid.
REQ-006 Port in_rdy, output, 1: block can accept a token.
REQ-007 Port in_idx, input, 5: MSB-first index; 0 means bit 31, 31 means bit 0.
REQ-008 Port in_empty, input, 1: token carries no index (encoder val=0); in_idx is ignored.
REQ-009 Port in_last, input, 1: final token of the current mask.
REQ-010 Port out_val, output, 1: rebuilt mask valid.
REQ-011 Port out_rdy, input, 1: consumer accepts the mask.
REQ-012 Port out_mask, output, 32: rebuilt bitmask.
REQ-013 Port out_cnt, output, CNT_W: number of accepted non-empty tokens, saturating.
REQ-014 Port out_dup, output, 1: at least one accepted index was already set.

Function
REQ-015 Block SHALL be the inverse of the 32-to-5 MSB-first priority encoder: accepted index k SHALL set accumulator bit (31-k).
REQ-016 FSM SHALL have exactly two states, ACCUM and HOLD; the reset state SHALL be ACCUM.
REQ-017 in_rdy SHALL equal 1 in ACCUM and 0 in HOLD, and SHALL be driven from a register, not from out_rdy.
REQ-018 A token SHALL be accepted on a cycle with in_val=1 and in_rdy=1; tokens presented with in_rdy=0 SHALL have no effect.
REQ-019 On an accepted token with in_empty=0, the accumulator bit SHALL be ORed in and the count incremented, saturating at 63.
REQ-020 On an accepted token with in_empty=1, the mask and count SHALL be unchanged.
REQ-021 On an accepted non-empty token whose target bit is already 1, dup SHALL be set sticky for the current mask.
REQ-022 An accepted token with in_last=1 SHALL apply its own contribution and move the FSM to HOLD; out_val SHALL be 1 on the next cycle, giving 1-cycle latency.
REQ-023 In HOLD, out_mask, out_cnt and out_dup SHALL be stable while out_val=1 and out_rdy=0.
REQ-024 On out_val=1 and out_rdy=1, the mask, count and dup SHALL clear to 0 and the FSM SHALL return to ACCUM; in_rdy SHALL be 1 on the next cycle.
REQ-025 out_val SHALL equal 1 only in HOLD.
REQ-026 out_mask, out_cnt and out_dup SHALL be driven directly from the accumulator registers, and are meaningful only while out_val=1.
REQ-027 A single token with in_last=1 and in_empty=1 SHALL produce mask 0, count 0 and dup 0, representing an all-zero mask.
REQ-028 Sustained throughput SHALL be one mask per (token count + 1) cycles when out_rdy is held at 1.

Reset
REQ-029 While rst_n=0, the block SHALL asynchronously force state ACCUM, mask 0, count 0, dup 0 and out_val 0.
REQ-030 On rst_n deassertion, in_rdy SHALL be 1 from the first rising clock edge after release.
REQ-031 A reset asserted mid-mask or in HOLD SHALL discard the partial or pending mask, and no output handshake SHALL follow it.

Verification
REQ-032 Tokens idx 0, 31 (last) with out_rdy=1 -> out_val=1 one cycle after the last token, out_mask=0x80000001, out_cnt=2, out_dup=0.
REQ-033 Tokens idx 5, 5 (last) -> out_mask=0x04000000, out_cnt=2, out_dup=1.
REQ-034 Single token in_empty=1 and in_last=1 -> out_mask=0, out_cnt=0, out_val=1 on the next cycle.
REQ-035 Mask completes with out_rdy=0 for 4 cycles -> outputs stable, in_rdy=0, and in_val tokens ignored; after out_rdy=1 for one cycle -> in_rdy=1 on the next cycle with a cleared accumulator.
REQ-036 Random 32-bit masks are fed through the reference priority-encode-and-clear loop, one token per set bit, with random out_rdy stalls -> out_mask equals the original mask and out_cnt equals its popcount.
REQ-037 rst_n pulsed low after 3 tokens of a mask -> out_val=0 and mask=0 immediately, with no stale bits in the next mask.
